// File: rtl/shift_pipe_multi.sv
// Pipelined multi-mode log-shifter (SLL/SRL/SRA/ROL), one registered stage per amount bit.
// Optional macro SHIFT_PIPE_ROTATE_EN enables ROL on op 11; otherwise op 11 behaves as SLL.
module shift_pipe_multi #(
  parameter int WIDTH = 8,
  parameter int BW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [BW-1:0]    b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int CTL_N  = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] o,
                                                   input logic sg,
                                                   input int sh);
    logic [2*WIDTH-1:0] ext;
    ext = '0;
    case (o)
      2'b01: stage_shift = d >> sh;
      2'b10: begin
        ext = {{WIDTH{sg}}, d} >> sh;
        stage_shift = ext[WIDTH-1:0];
      end
`ifdef SHIFT_PIPE_ROTATE_EN
      2'b11: stage_shift = (d << sh) | (d >> (WIDTH - sh));
`endif
      default: stage_shift = d << sh;
    endcase
  endfunction

  // Saturates an overrange result; rotate keeps its modulo-WIDTH result.
  function automatic logic [WIDTH-1:0] apply_ovr(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] o,
                                                 input logic sg,
                                                 input logic ovr);
    if (!ovr) begin
      apply_ovr = d;
    end else begin
      case (o)
        2'b10: apply_ovr = {WIDTH{sg}};
`ifdef SHIFT_PIPE_ROTATE_EN
        2'b11: apply_ovr = d;
`endif
        default: apply_ovr = '0;
      endcase
    end
  endfunction

  logic [WIDTH-1:0]  data_p [STAGES];
  logic              vld_p  [STAGES];
  logic [1:0]        op_p   [CTL_N];
  logic [STAGES-1:0] amt_p  [CTL_N];
  logic              sgn_p  [CTL_N];
  logic              ovr_p  [CTL_N];
  logic              advance;
  logic              in_ovr;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p[STAGES-1];
  assign s         = data_p[STAGES-1];

  if (BW > STAGES) begin : g_ovr
    assign in_ovr = |b[BW-1:STAGES];
  end else begin : g_no_ovr
    assign in_ovr = 1'b0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]  d_in;
    logic [WIDTH-1:0]  d_sh;
    logic [WIDTH-1:0]  d_nxt;
    logic [1:0]        o_in;
    logic [STAGES-1:0] a_in;
    logic              sg_in;
    logic              ov_in;
    logic              v_in;

    if (k == 0) begin : g_first
      assign d_in  = a;
      assign o_in  = op;
      assign a_in  = b[STAGES-1:0];
      assign sg_in = a[WIDTH-1];
      assign ov_in = in_ovr;
      assign v_in  = in_valid;
    end else begin : g_rest
      assign d_in  = data_p[k-1];
      assign o_in  = op_p[k-1];
      assign a_in  = amt_p[k-1];
      assign sg_in = sgn_p[k-1];
      assign ov_in = ovr_p[k-1];
      assign v_in  = vld_p[k-1];
    end

    // The amount word is shifted down each stage, so bit 0 is always this stage's bit.
    assign d_sh = a_in[0] ? stage_shift(d_in, o_in, sg_in, 1 << k) : d_in;

    if (k == STAGES - 1) begin : g_last
      logic unused_amt;
      assign unused_amt = ^a_in;
      assign d_nxt      = apply_ovr(d_sh, o_in, sg_in, ov_in);
    end else begin : g_mid
      assign d_nxt = d_sh;
      // stage k -> k+1 control boundary
      always_ff @(posedge clk) begin
        if (rst) begin
          op_p[k]  <= '0;
          amt_p[k] <= '0;
          sgn_p[k] <= 1'b0;
          ovr_p[k] <= 1'b0;
        end else if (advance) begin
          op_p[k]  <= o_in;
          amt_p[k] <= a_in >> 1;
          sgn_p[k] <= sg_in;
          ovr_p[k] <= ov_in;
        end
      end
    end

    // stage k data/valid boundary
    always_ff @(posedge clk) begin
      if (rst) begin
        data_p[k] <= '0;
        vld_p[k]  <= 1'b0;
      end else if (advance) begin
        data_p[k] <= d_nxt;
        vld_p[k]  <= v_in;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe_multi.sv
// Scoreboard bench for shift_pipe_multi (WIDTH=8, BW=8); honours SHIFT_PIPE_ROTATE_EN.
module tb_shift_pipe_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic [1:0] op_i = '0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;

  logic rdy_ctl  = 1'b1;
  logic rnd_rdy  = 1'b1;
  logic rand_rdy = 1'b0;
  logic strict_lat = 1'b1;
  logic done = 1'b0;
  logic final_done = 1'b0;
  int   tmo_cnt = 0;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;

  assign out_ready = rand_rdy ? rnd_rdy : rdy_ctl;

  shift_pipe_multi #(.WIDTH(8), .BW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .op(op_i), .out_valid(out_valid),
    .out_ready(out_ready), .s(s)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Reference: shift rules applied with plain arithmetic on the whole amount.
  function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [1:0] mop);
    logic signed [7:0] sa;
    int amt;
    int r;
    logic [1:0] m;
    sa = ma;
    amt = int'(mb);
    m = mop;
`ifndef SHIFT_PIPE_ROTATE_EN
    if (m == 2'b11) m = 2'b00;
`endif
    case (m)
      2'b00: return (amt >= 8) ? 8'h00 : 8'(ma << amt);
      2'b01: return (amt >= 8) ? 8'h00 : 8'(ma >> amt);
      2'b10: begin
        if (amt >= 8) return {8{ma[7]}};
        sa = sa >>> amt;
        return sa;
      end
      default: begin
        r = amt % 8;
        return 8'((ma << r) | (ma >> (8 - r)));
      end
    endcase
  endfunction

  typedef struct {
    logic [7:0] v;
    int         acc;
  } exp_t;
  exp_t q[$];

  logic       prev_ov = 1'b0;
  logic       prev_drain = 1'b0;
  logic       prev_hold = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] prev_s = '0;
  int         present = 0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      vectors++;
      if (out_valid !== 1'b0 || s !== 8'h00 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_state: out_valid=%b s=%h in_ready=%b, required 0/00/1",
                 out_valid, s, in_ready);
      end
    end
    if (rst) begin
      q.delete();
    end else begin
      if (prev_hold) begin
        vectors++;
        if (out_valid !== 1'b1 || s !== prev_s) begin
          fails++;
          $display("FAIL stall_hold: out_valid=%b s=%h, required 1/%h", out_valid, s, prev_s);
        end
      end
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_in_ready: in_ready=%b, required 0", in_ready);
        end
      end
      if (out_valid && (!prev_ov || prev_drain)) begin
        present = cyc;
        vectors++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL spurious_out: s=%h appeared, required no result", s);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (s !== e.v) begin
          fails++;
          $display("FAIL result: s=%h, required %h", s, e.v);
        end
        vectors++;
        if ((strict_lat && (present - e.acc) != 3) || (present - e.acc) < 3) begin
          fails++;
          $display("FAIL latency: got %0d cycles, required %s3", present - e.acc,
                   strict_lat ? "" : ">=");
        end
      end
      if (in_valid && in_ready) q.push_back('{model(a_i, b_i, op_i), cyc});
    end
    if (done && !final_done) begin
      vectors++;
      if (q.size() != 0 || tmo_cnt != 0) begin
        fails++;
        $display("FAIL drain: %0d results outstanding, %0d accept timeouts, required 0/0",
                 q.size(), tmo_cnt);
      end
      final_done <= 1'b1;
    end
    prev_rst   = rst;
    prev_ov    = out_valid;
    prev_drain = out_valid && out_ready && !rst;
    prev_hold  = out_valid && !out_ready && !rst;
    prev_s     = s;
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic [1:0] top);
    int n;
    in_valid = 1'b1;
    a_i = ta;
    b_i = tbv;
    op_i = top;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) tmo_cnt++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } vec_t;
  vec_t dir[$];

  initial begin
    dir = '{'{8'hB5, 8'd3, 2'b00}, '{8'hB5, 8'd3, 2'b01}, '{8'h96, 8'd2, 2'b10},
            '{8'h81, 8'd1, 2'b11}, '{8'hFF, 8'd9, 2'b01}, '{8'h01, 8'd8, 2'b00},
            '{8'h80, 8'd200, 2'b10}, '{8'h7F, 8'd8, 2'b10}};
`ifdef SHIFT_PIPE_ROTATE_EN
    dir.push_back('{8'h81, 8'd9, 2'b11});
`endif
    idle(3);
    rst = 1'b0;
    idle(2);

    foreach (dir[i]) begin
      send(dir[i].a, dir[i].b, dir[i].op);
      idle(4);
    end

    // Backpressure: five beats into a stalled output, released later.
    strict_lat = 1'b0;
    rdy_ctl = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send(8'h01, 8'(i), 2'b00);
      begin
        idle(9);
        rdy_ctl = 1'b1;
      end
    join
    idle(8);

    // Bubbles: one beat every other cycle.
    strict_lat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 8'($urandom_range(0, 7)), 2'($urandom));
      idle(1);
    end
    idle(5);

    // Reset with beats in flight, plus a beat offered during reset.
    for (int i = 0; i < 3; i++) send(8'hC3 + 8'(i), 8'd1, 2'b01);
    rst = 1'b1;
    in_valid = 1'b1;
    a_i = 8'h55;
    b_i = 8'd0;
    op_i = 2'b00;
    idle(1);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(6);
    send(8'h80, 8'd7, 2'b01);
    idle(5);

    // Random traffic with random backpressure.
    strict_lat = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7)),
           2'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    rand_rdy = 1'b0;
    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    idle(2);
    done = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/shift_pipe_multi.md
# shift_pipe_multi

Pipelined, parametrised multi-mode shifter, the successor of the 8-bit combinational shift-left unit in the arithmetic operations set. It performs logical left, logical right, arithmetic right and rotate-left on a WIDTH-bit operand. The log-shifter is split into one registered stage per shift-amount bit, with a valid/ready handshake on both sides. It sits between operand issue and result writeback in the arithmetic datapath.

## Interface
- WIDTH, 8: operand/result width; must be a power of two, ≥ 2.
- BW, 8: shift-amount port width; must be ≥ LOG2W = $clog2(WIDTH).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand.
- b  input  BW  shift amount, unsigned.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  result.

## Operation
- Pipeline has LOG2W stages. Stage k (k = 0..LOG2W-1) applies a shift of 2^k when amount bit b[k] is set, else it passes the data. The stage then registers data, op, the remaining amount bits, ovr and valid.
- SLL/SRL fill with zero. SRA fills with a[WIDTH-1], captured at input and carried along. ROL wraps the bits shifted out of the top back into bit 0.
- Overrange: ovr = OR of b[BW-1:LOG2W], computed at input; it is 0 when BW = LOG2W. The last stage applies the override when ovr is set:
  - SLL/SRL: s = 0.
  - SRA: s = all copies of the sign bit.
  - ROL: ovr is ignored, so the rotate amount is b mod WIDTH.
- Global stall: advance = !out_valid || out_ready. While advance = 1, every stage shifts forward one position and the input is captured into stage 0. While advance = 0, all stages hold.
- in_ready = advance, a combinational function of out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- A beat is accepted when in_valid && in_ready. Empty slots travel as bubbles (valid = 0). Results leave in acceptance order; there is no loss and no duplication.
- Stage valid bits, and out_valid, are taken from the last stage register.

## Timing
- Latency: a beat accepted at edge N presents out_valid = 1 with s valid after edge N+LOG2W, when there is no stall. For WIDTH=8 that is 3 cycles.
- Throughput: one beat per cycle while out_ready stays high.
- s and out_valid stay stable while out_valid && !out_ready.
- Simultaneous accept and drain in the same cycle is legal, and the pipeline stays full at full rate.
- Reset (rst = 1 at an edge) clears all stage valids and out_valid to 0, and clears all data registers and s to 0. Beats in flight are discarded; there is no partial output.
- During reset, in_ready = 1 because out_valid = 0. Beats presented while rst = 1 are not retained.
- Values of a, b and op are don't-care when in_valid = 0.

## Configuration
- SHIFT_PIPE_ROTATE_EN:
  - Defined: op 11 performs ROL as described above.
  - Undefined: the rotate wrap logic is compiled out, op 11 decodes as SLL, including the overrange rule, and the remaining behaviour is unchanged.

## Test plan
- Basic modes (WIDTH=8, BW=8, out_ready=1):
  - SLL a=8'hB5, b=3 → s=8'hA8 three cycles after acceptance.
  - SRL a=8'hB5, b=3 → 8'h16.
  - SRA a=8'h96, b=2 → 8'hE5.
- Rotate: op=11, a=8'h81, b=1 → 8'h03 with SHIFT_PIPE_ROTATE_EN defined, 8'h02 without. With the macro defined, a=8'h81, b=9 → 8'h03.
- Overrange:
  - SRL a=8'hFF, b=9 → 8'h00.
  - SLL a=8'h01, b=8 → 8'h00.
  - SRA a=8'h80, b=200 → 8'hFF.
  - SRA a=8'h7F, b=8 → 8'h00.
- Backpressure: send 5 back-to-back beats (SLL a=1, b=0..4), hold out_ready=0 for 6 cycles, then release.
  - During the stall, in_ready drops within 1 cycle and s holds steady.
  - After release, outputs arrive in order 01, 02, 04, 08, 10 with none lost or duplicated.
- Bubbles: send beats on alternate cycles with out_ready=1 → out_valid alternates with the same spacing, latency 3.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle one cycle later.
  - out_valid=0 and s=0 on the next cycle.
  - No pre-reset result ever appears.
  - A new beat accepted after reset (SRL a=8'h80, b=7) gives 8'h01 three cycles later.
